// File: rtl/pipe_fetch_ctrl_if.sv
// pipe_fetch_ctrl_if
//   Fetch handshake between the IF sequencing controller and the
//   instruction memory.
//   imem_req : controller -> memory, fetch request at the current PC
//   imem_ack : memory -> controller, instruction valid this cycle
//              (meaningful only while imem_req is high)
interface pipe_fetch_ctrl_if;
    logic imem_req;
    logic imem_ack;

    modport master (output imem_req, input imem_ack);
    modport slave  (input imem_req, output imem_ack);
endinterface

// File: rtl/pipe_fetch_ctrl.sv
// pipe_fetch_ctrl
//   Sequencing controller for the IF stage of the 5-stage pipeline.
//   Drives PC write enable, next-PC select, IF/ID write/flush and the
//   ID/EX bubble. Handles a variable-latency instruction memory,
//   load-use hazards from EX and taken branches resolved in ID.
//
//   Ports:
//     clk             clock, rising edge
//     clrn            asynchronous reset, active-high
//     imem            fetch handshake (master side: req out, ack in)
//     id_valid        IF/ID holds a real instruction
//     id_rs, id_rt    source register fields of the ID instruction
//     id_uses_rt      ID instruction reads rt
//     id_branch_taken branch/jump resolved taken in ID
//     ex_memread      EX instruction is a load
//     ex_rd           destination register of the EX instruction
//     pc_we           PC write enable
//     pc_sel          0 = PC+4, 1 = branch target
//     ifid_we         IF/ID write enable
//     ifid_flush      clear IF/ID to a bubble on the next edge
//     idex_bubble     bubble into ID/EX, hold ID
//     fetch_err       sticky memory-timeout flag
//     stall_cnt       saturating count of stall cycles
module pipe_fetch_ctrl #(
    parameter int unsigned RESET_DELAY = 2,
    parameter int unsigned MAX_WAIT    = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clk,
    input  logic               clrn,
    pipe_fetch_ctrl_if.master  imem,
    input  logic               id_valid,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               id_uses_rt,
    input  logic               id_branch_taken,
    input  logic               ex_memread,
    input  logic [4:0]         ex_rd,
    output logic               pc_we,
    output logic               pc_sel,
    output logic               ifid_we,
    output logic               ifid_flush,
    output logic               idex_bubble,
    output logic               fetch_err,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [3:0] DLY_LAST = 4'(RESET_DELAY - 1);
    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    state_t     state_q, state_d;
    logic [3:0] dly_q, dly_d;
    logic [7:0] wait_q, wait_d;
    logic [7:0] wait_inc;
    logic       timeout;
    logic       hazard;
    logic       stall_inc;
    logic       err_set;

    assign hazard = id_valid & ex_memread & (ex_rd != '0) &
                    ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

    // The miss happening this cycle would bring the wait count to MAX_WAIT.
    assign wait_inc = wait_q + 8'd1;
    assign timeout  = (wait_inc == WAIT_LIM);

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state_q   <= S_INIT;
            dly_q     <= '0;
            wait_q    <= '0;
            stall_cnt <= '0;
            fetch_err <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            wait_q  <= wait_d;
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (err_set)
                fetch_err <= 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        dly_d         = dly_q;
        wait_d        = wait_q;
        stall_inc     = 1'b0;
        err_set       = 1'b0;
        imem.imem_req = 1'b0;
        pc_we         = 1'b0;
        pc_sel        = 1'b0;
        ifid_we       = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;

        unique case (state_q)
            S_INIT: begin
                if (dly_q == DLY_LAST)
                    state_d = S_FETCH;
                else
                    dly_d = dly_q + 4'd1;
            end

            S_FETCH: begin
                if (hazard) begin
                    // No request: any ack this cycle is ignored by contract.
                    idex_bubble = 1'b1;
                    stall_inc   = 1'b1;
                end else if (id_branch_taken) begin
                    imem.imem_req = 1'b1;
                    pc_we         = 1'b1;
                    pc_sel        = 1'b1;
                    ifid_flush    = 1'b1;
                    if (imem.imem_ack) begin
                        wait_d = '0;
                    end else begin
                        // Wrong-path fetch still outstanding; keep ageing it.
                        wait_d = wait_inc;
                        if (timeout) begin
                            err_set = 1'b1;
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end
                end else begin
                    imem.imem_req = 1'b1;
                    if (imem.imem_ack) begin
                        pc_we   = 1'b1;
                        ifid_we = 1'b1;
                        wait_d  = '0;
                    end else begin
                        stall_inc = 1'b1;
                        wait_d    = wait_inc;
                        if (timeout) begin
                            err_set = 1'b1;
                            state_d = S_ERR;
                        end
                    end
                end
            end

            S_DRAIN: begin
                imem.imem_req = 1'b1;
                ifid_flush    = 1'b1;
                stall_inc     = 1'b1;
                if (imem.imem_ack) begin
                    wait_d  = '0;
                    state_d = S_FETCH;
                end else begin
                    wait_d = wait_inc;
                    if (timeout) begin
                        err_set = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end

            S_ERR: begin
            end

            default: state_d = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_pipe_fetch_ctrl.sv
// tb_pipe_fetch_ctrl
//   Directed scoreboard bench for pipe_fetch_ctrl. Each driven cycle pushes
//   the expected output vector; a monitor pops and compares it mid-cycle.
module tb_pipe_fetch_ctrl;

    logic        clk;
    logic        clrn;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_branch_taken;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        pc_we;
    logic        pc_sel;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        fetch_err;
    logic [15:0] stall_cnt;

    pipe_fetch_ctrl_if imem_bus();

    pipe_fetch_ctrl #(
        .RESET_DELAY (2),
        .MAX_WAIT    (8),
        .CNT_W       (16)
    ) dut (
        .clk             (clk),
        .clrn            (clrn),
        .imem            (imem_bus),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_branch_taken (id_branch_taken),
        .ex_memread      (ex_memread),
        .ex_rd           (ex_rd),
        .pc_we           (pc_we),
        .pc_sel          (pc_sel),
        .ifid_we         (ifid_we),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .fetch_err       (fetch_err),
        .stall_cnt       (stall_cnt)
    );

    typedef struct packed {
        logic        req;
        logic        pc_we;
        logic        pc_sel;
        logic        ifid_we;
        logic        flush;
        logic        bubble;
        logic        err;
        logic [15:0] stall;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [15:0] s;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Push one cycle's expectation, then advance to the next drive point.
    task automatic step(input logic r, input logic w, input logic sl, input logic iw,
                        input logic f, input logic b, input logic e, input logic [15:0] st);
        exp_t x;
        x = {r, w, sl, iw, f, b, e, st};
        sb.push_back(x);
        @(negedge clk);
    endtask

    task automatic idle_c();     step(0, 0, 0, 0, 0, 0, 0, s); endtask
    task automatic fetch_ok();   step(1, 1, 0, 1, 0, 0, 0, s); endtask
    task automatic fetch_wait(); step(1, 0, 0, 0, 0, 0, 0, s); endtask
    task automatic bubble_c();   step(0, 0, 0, 0, 0, 1, 0, s); endtask
    task automatic branch_c();   step(1, 1, 1, 0, 1, 0, 0, s); endtask
    task automatic drain_c();    step(1, 0, 0, 0, 1, 0, 0, s); endtask
    task automatic err_c();      step(0, 0, 0, 0, 0, 0, 1, s); endtask

    // Monitor: sample 2 time units after the falling edge, well clear of posedge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check_eq("imem_req",    32'(imem_bus.imem_req), 32'(x.req));
                check_eq("pc_we",       32'(pc_we),             32'(x.pc_we));
                check_eq("pc_sel",      32'(pc_sel),            32'(x.pc_sel));
                check_eq("ifid_we",     32'(ifid_we),           32'(x.ifid_we));
                check_eq("ifid_flush",  32'(ifid_flush),        32'(x.flush));
                check_eq("idex_bubble", 32'(idex_bubble),       32'(x.bubble));
                check_eq("fetch_err",   32'(fetch_err),         32'(x.err));
                check_eq("stall_cnt",   32'(stall_cnt),         32'(x.stall));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b1;
        imem_bus.imem_ack = 1'b0;
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        id_branch_taken = 1'b0; ex_memread = 1'b0; ex_rd = '0;
        s = '0;
        @(negedge clk);

        // Reset state, then RESET_DELAY idle cycles, request on cycle 3
        idle_c();
        clrn = 1'b0; imem_bus.imem_ack = 1'b1;
        idle_c(); idle_c();
        repeat (4) fetch_ok();

        // Load-use hazard on rs (ack high but request is low)
        id_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        bubble_c(); s = 16'd1;
        ex_memread = 1'b0;
        fetch_ok();
        // Load to r0 never stalls
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
        fetch_ok();
        // rt match only counts when rt is used
        ex_rd = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
        fetch_ok();
        id_uses_rt = 1'b1;
        bubble_c(); s = 16'd2;
        ex_memread = 1'b0; id_uses_rt = 1'b0;
        fetch_ok();

        // Branch with ack in the same cycle: no drain
        id_branch_taken = 1'b1;
        branch_c();
        id_branch_taken = 1'b0;
        fetch_ok();

        // Branch with ack delayed: three drain cycles
        id_branch_taken = 1'b1; imem_bus.imem_ack = 1'b0;
        branch_c();
        id_branch_taken = 1'b0;
        drain_c(); s = 16'd3;
        drain_c(); s = 16'd4;
        imem_bus.imem_ack = 1'b1;
        drain_c(); s = 16'd5;
        fetch_ok();

        // Branch together with hazard: bubble first, branch next cycle
        id_branch_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        bubble_c(); s = 16'd6;
        ex_memread = 1'b0;
        branch_c();
        id_branch_taken = 1'b0;
        fetch_ok();

        // Timeout after MAX_WAIT missed cycles
        imem_bus.imem_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fetch_wait(); s = s + 16'd1;
        end
        err_c();
        id_branch_taken = 1'b1; ex_memread = 1'b1;
        err_c();
        imem_bus.imem_ack = 1'b1; id_branch_taken = 1'b0; ex_memread = 1'b0;
        err_c();

        // Reset clears the error and restarts from INIT
        clrn = 1'b1; s = '0;
        idle_c();
        clrn = 1'b0;
        idle_c(); idle_c();
        fetch_ok(); fetch_ok();

        #3;
        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
